hazard_tracker: RTL and testbench

- Parametrised stall/forward unit for the pipelined MIPS core. It replaces the purely combinational Tuse/Tnew decode with a tracker that carries each in-flight producer's destination and remaining Tnew down an NSTAGE-deep scoreboard.
- Each cycle it compares the decode-stage instruction's source registers and Tuse against the scoreboard. From that it raises stall and selects the D-stage forwarding source.
- It also keeps a saturating stall counter for performance debug.

---
 rtl/hazard_tracker.sv | 100 ++++++++++
 tb/tb_hazard_tracker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// Scoreboard-based stall/forward unit: tracks in-flight producers (dst, remaining Tnew)
// down NSTAGE post-decode stages and resolves D-stage source hazards against them.
module hazard_tracker #(
    parameter int NSTAGE = 3,
    parameter int TW     = 2,
    parameter int RW     = 5,
    parameter int SW     = 2,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_d,
    input  logic [RW-1:0] rs_d,
    input  logic [RW-1:0] rt_d,
    input  logic          use_rs_d,
    input  logic          use_rt_d,
    input  logic [TW-1:0] tuse_rs_d,
    input  logic [TW-1:0] tuse_rt_d,
    input  logic          wr_d,
    input  logic [RW-1:0] dst_d,
    input  logic [TW-1:0] tnew_d,
    input  logic          flush_e,
    output logic          stall,
    output logic [SW-1:0] fwd_sel_rs,
    output logic [SW-1:0] fwd_sel_rt,
    output logic [CW-1:0] stall_cnt
);

    logic [NSTAGE:1] v_r;
    logic [RW-1:0]   dst_r [1:NSTAGE];
    logic [TW-1:0]   tn_r  [1:NSTAGE];

    logic [NSTAGE:1] match_rs_s;
    logic [NSTAGE:1] match_rt_s;
    logic [SW-1:0]   k_rs_s;
    logic [SW-1:0]   k_rt_s;
    logic [TW-1:0]   tn_rs_s;
    logic [TW-1:0]   tn_rt_s;
    logic            hit_rs_s;
    logic            hit_rt_s;
    logic            load_s;

    // Nearest-match search: scanning oldest to youngest lets the youngest match win.
    always_comb begin
        k_rs_s  = {SW{1'b0}};
        k_rt_s  = {SW{1'b0}};
        tn_rs_s = {TW{1'b0}};
        tn_rt_s = {TW{1'b0}};
        for (int k = NSTAGE; k >= 1; k--) begin
            match_rs_s[k] = v_r[k] && (dst_r[k] == rs_d) && (rs_d != {RW{1'b0}}) && use_rs_d && valid_d;
            match_rt_s[k] = v_r[k] && (dst_r[k] == rt_d) && (rt_d != {RW{1'b0}}) && use_rt_d && valid_d;
            k_rs_s  = match_rs_s[k] ? SW'(k) : k_rs_s;
            tn_rs_s = match_rs_s[k] ? tn_r[k] : tn_rs_s;
            k_rt_s  = match_rt_s[k] ? SW'(k) : k_rt_s;
            tn_rt_s = match_rt_s[k] ? tn_r[k] : tn_rt_s;
        end
        hit_rs_s = |match_rs_s;
        hit_rt_s = |match_rt_s;
    end

    // Hazard resolution and forwarding select, same-cycle with the D inputs.
    always_comb begin
        stall      = (hit_rs_s && (tn_rs_s > tuse_rs_d)) || (hit_rt_s && (tn_rt_s > tuse_rt_d));
        fwd_sel_rs = (hit_rs_s && (tn_rs_s == {TW{1'b0}})) ? k_rs_s : {SW{1'b0}};
        fwd_sel_rt = (hit_rt_s && (tn_rt_s == {TW{1'b0}})) ? k_rt_s : {SW{1'b0}};
        load_s     = !stall && !flush_e && valid_d && wr_d && (dst_d != {RW{1'b0}});
    end

    // Scoreboard shift: stage 1 takes the issuing producer or a bubble, older stages age.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r <= {NSTAGE{1'b0}};
            for (int k = 1; k <= NSTAGE; k++) begin
                dst_r[k] <= {RW{1'b0}};
                tn_r[k]  <= {TW{1'b0}};
            end
        end else begin
            v_r[1]   <= load_s;
            dst_r[1] <= dst_d;
            tn_r[1]  <= tnew_d;
            for (int k = 1; k < NSTAGE; k++) begin
                v_r[k+1]   <= v_r[k];
                dst_r[k+1] <= dst_r[k];
                tn_r[k+1]  <= (tn_r[k] == {TW{1'b0}}) ? {TW{1'b0}} : tn_r[k] - TW'(1);
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= {CW{1'b0}};
        end else if (stall && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + CW'(1);
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed pipeline scenarios plus random stimulus against an
// age-based producer-list model, on a default instance and a deep/narrow-counter instance.
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_d, use_rs_d, use_rt_d, wr_d, flush_e;
    logic [4:0] rs_d, rt_d, dst_d;
    logic [2:0] tuse_rs, tuse_rt, tnew;

    logic        stall3, stall5;
    logic [1:0]  fs_rs3, fs_rt3;
    logic [2:0]  fs_rs5, fs_rt5;
    logic [15:0] cnt3;
    logic [3:0]  cnt5;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_tracker dut3 (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
        .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .tuse_rs_d(tuse_rs[1:0]), .tuse_rt_d(tuse_rt[1:0]),
        .wr_d(wr_d), .dst_d(dst_d), .tnew_d(tnew[1:0]), .flush_e(flush_e),
        .stall(stall3), .fwd_sel_rs(fs_rs3), .fwd_sel_rt(fs_rt3), .stall_cnt(cnt3)
    );

    hazard_tracker #(.NSTAGE(5), .TW(3), .RW(5), .SW(3), .CW(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
        .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .tuse_rs_d(tuse_rs), .tuse_rt_d(tuse_rt),
        .wr_d(wr_d), .dst_d(dst_d), .tnew_d(tnew), .flush_e(flush_e),
        .stall(stall5), .fwd_sel_rs(fs_rs5), .fwd_sel_rt(fs_rt5), .stall_cnt(cnt5)
    );

    // Reference model: each producer remembers the cycle it entered E; its stage and
    // remaining latency follow from its age.
    typedef struct {
        logic [4:0] dst;
        int         tnew;
        int         born;
    } prod_t;

    prod_t q3[$];
    prod_t q5[$];
    int    cyc = 0;
    int    mcnt3 = 0;
    int    mcnt5 = 0;

    function automatic void eval_src(input int which, input logic [4:0] s, input logic u,
                                     input int tuse, output logic haz, output int sel);
        int ns, n, best, rem, k;
        prod_t p;
        ns = (which == 0) ? 3 : 5;
        n = (which == 0) ? q3.size() : q5.size();
        haz = 1'b0; sel = 0; best = 0; rem = 0;
        if (valid_d && u && s != 5'd0) begin
            for (int i = 0; i < n; i++) begin
                p = (which == 0) ? q3[i] : q5[i];
                k = cyc - p.born + 1;
                if (k >= 1 && k <= ns && p.dst == s && (best == 0 || k < best)) begin
                    best = k;
                    rem = p.tnew - (k - 1);
                    if (rem < 0) rem = 0;
                end
            end
            if (best != 0) begin
                haz = rem > tuse;
                sel = (rem == 0) ? best : 0;
            end
        end
    endfunction

    function automatic int tu(input int which, input logic [2:0] t);
        return (which == 0) ? int'(t[1:0]) : int'(t);
    endfunction

    function automatic logic model_stall(input int which);
        logic h1, h2;
        int s1, s2;
        eval_src(which, rs_d, use_rs_d, tu(which, tuse_rs), h1, s1);
        eval_src(which, rt_d, use_rt_d, tu(which, tuse_rt), h2, s2);
        return h1 | h2;
    endfunction

    task automatic tick();
        logic s3, s5;
        s3 = model_stall(0);
        s5 = model_stall(1);
        @(posedge clk);
        if (!s3 && !flush_e && valid_d && wr_d && dst_d != 5'd0)
            q3.push_back('{dst_d, tu(0, tnew), cyc + 1});
        if (!s5 && !flush_e && valid_d && wr_d && dst_d != 5'd0)
            q5.push_back('{dst_d, tu(1, tnew), cyc + 1});
        if (s3 && mcnt3 < 65535) mcnt3 = mcnt3 + 1;
        if (s5 && mcnt5 < 15) mcnt5 = mcnt5 + 1;
        cyc = cyc + 1;
        #1;
    endtask

    task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [2:0] trs,
                         input logic [2:0] trt, input logic wr, input logic [4:0] dst,
                         input logic [2:0] tn);
        valid_d = v; rs_d = rs; rt_d = rt; use_rs_d = urs; use_rt_d = urt;
        tuse_rs = trs; tuse_rt = trt; wr_d = wr; dst_d = dst; tnew = tn; flush_e = 1'b0;
    endtask

    task automatic set_idle();
        set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q3.delete(); q5.delete(); mcnt3 = 0; mcnt5 = 0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_d(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 5'd3, 3'd3);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall3); end
        checks++; if (fs_rs3 !== 2'd0 || fs_rt3 !== 2'd0) begin failures++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", fs_rs3, fs_rt3); end
        checks++; if (cnt3 !== 16'd0 || cnt5 !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt3, cnt5); end
        set_idle();
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_load_use();
        do_reset();
        set_d(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 3'd1, 3'd0, 1'b1, 5'd2, 3'd2);
        #1;
        checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL lu_issue got=%0d exp=0", stall3); end
        tick();
        set_d(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 3'd1, 3'd1, 1'b1, 5'd3, 3'd1);
        #1;
        checks++; if (stall3 !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", stall3); end
        tick();
        checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL lu_release got=%0d exp=0", stall3); end
        checks++; if (cnt3 !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", cnt3); end
        set_idle();
    endtask

    task automatic test_branch_after_alu();
        do_reset();
        set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 5'd4, 3'd1);
        tick();
        set_d(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
        #1;
        checks++; if (stall3 !== 1'b1) begin failures++; $display("FAIL br_stall got=%0d exp=1", stall3); end
        tick();
        checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL br_release got=%0d exp=0", stall3); end
        checks++; if (fs_rs3 !== 2'd2 || fs_rt3 !== 2'd2) begin failures++; $display("FAIL br_fwd got=%0d/%0d exp=2/2", fs_rs3, fs_rt3); end
        set_idle();
    endtask

    task automatic test_shadowing();
        do_reset();
        set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 5'd5, 3'd1);
        tick();
        set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 5'd5, 3'd2);
        tick();
        set_d(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
        #1;
        checks++; if (stall3 !== 1'b1 || fs_rs3 !== 2'd0) begin failures++; $display("FAIL shadow_first got=%0d/%0d exp=1/0", stall3, fs_rs3); end
        tick();
        checks++; if (stall3 !== 1'b1 || fs_rs3 !== 2'd0) begin failures++; $display("FAIL shadow_second got=%0d/%0d exp=1/0", stall3, fs_rs3); end
        tick();
        // the lw has aged to W with tn=0 and still shadows nothing older
        checks++; if (stall3 !== 1'b0 || fs_rs3 !== 2'd3) begin failures++; $display("FAIL shadow_fwd got=%0d/%0d exp=0/3", stall3, fs_rs3); end
        checks++; if (cnt3 !== 16'd2) begin failures++; $display("FAIL shadow_cnt got=%0d exp=2", cnt3); end
        set_idle();
    endtask

    task automatic test_zero_and_flush();
        do_reset();
        set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 5'd0, 3'd1);
        tick();
        set_d(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
        #1;
        checks++; if (stall3 !== 1'b0 || fs_rs3 !== 2'd0 || fs_rt3 !== 2'd0) begin failures++; $display("FAIL zero_reg got=%0d/%0d/%0d exp=0/0/0", stall3, fs_rs3, fs_rt3); end
        set_d(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 3'd1, 3'd0, 1'b1, 5'd6, 3'd2);
        flush_e = 1'b1;
        tick();
        set_d(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
        #1;
        checks++; if (stall3 !== 1'b0 || fs_rs3 !== 2'd0) begin failures++; $display("FAIL flush_drop got=%0d/%0d exp=0/0", stall3, fs_rs3); end
        set_idle();
    endtask

    task automatic test_depth();
        int n;
        do_reset();
        set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 5'd8, 3'd4);
        tick();
        set_d(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
        #1;
        n = 0;
        while (stall5 === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        checks++; if (n != 4) begin failures++; $display("FAIL depth_stalls got=%0d exp=4", n); end
        checks++; if (fs_rs5 !== 3'd5) begin failures++; $display("FAIL depth_fwd got=%0d exp=5", fs_rs5); end
        checks++; if (cnt5 !== 4'd4) begin failures++; $display("FAIL depth_cnt got=%0d exp=4", cnt5); end
        set_idle();
    endtask

    task automatic test_saturation_and_async_reset();
        do_reset();
        for (int p = 0; p < 7; p++) begin
            set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 5'd7, 3'd3);
            tick();
            set_d(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
            repeat (3) tick();
        end
        checks++; if (cnt5 !== 4'd15) begin failures++; $display("FAIL sat_cnt5 got=%0d exp=15", cnt5); end
        checks++; if (cnt3 !== 16'd21) begin failures++; $display("FAIL sat_cnt3 got=%0d exp=21", cnt3); end
        set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 5'd7, 3'd3);
        tick();
        set_d(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
        #1;
        checks++; if (stall3 !== 1'b1 || stall5 !== 1'b1) begin failures++; $display("FAIL midstall_pre got=%0d/%0d exp=1/1", stall3, stall5); end
        rst_n = 1'b0;
        q3.delete(); q5.delete(); mcnt3 = 0; mcnt5 = 0;
        #1;
        checks++; if (stall3 !== 1'b0 || stall5 !== 1'b0) begin failures++; $display("FAIL async_stall got=%0d/%0d exp=0/0", stall3, stall5); end
        checks++; if (cnt3 !== 16'd0 || cnt5 !== 4'd0) begin failures++; $display("FAIL async_cnt got=%0d/%0d exp=0/0", cnt3, cnt5); end
        rst_n = 1'b1;
        tick();
        checks++; if (stall3 !== 1'b0 || stall5 !== 1'b0 || fs_rs5 !== 3'd0) begin failures++; $display("FAIL async_empty got=%0d/%0d/%0d exp=0/0/0", stall3, stall5, fs_rs5); end
        set_idle();
    endtask

    task automatic test_random();
        logic h;
        int s_rs, s_rt;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            valid_d  = ($urandom_range(0, 7) != 0);
            rs_d     = 5'($urandom_range(0, 3));
            rt_d     = 5'($urandom_range(0, 3));
            use_rs_d = 1'($urandom_range(0, 1));
            use_rt_d = 1'($urandom_range(0, 1));
            tuse_rs  = 3'($urandom_range(0, 3));
            tuse_rt  = 3'($urandom_range(0, 3));
            wr_d     = ($urandom_range(0, 3) != 0);
            dst_d    = 5'($urandom_range(0, 3));
            tnew     = 3'($urandom_range(0, 3));
            flush_e  = ($urandom_range(0, 7) == 0);
            #1;
            checks++; if (stall3 !== model_stall(0)) begin failures++; $display("FAIL rnd_stall3 cyc=%0d got=%0d exp=%0d", i, stall3, model_stall(0)); end
            checks++; if (stall5 !== model_stall(1)) begin failures++; $display("FAIL rnd_stall5 cyc=%0d got=%0d exp=%0d", i, stall5, model_stall(1)); end
            eval_src(0, rs_d, use_rs_d, tu(0, tuse_rs), h, s_rs);
            eval_src(0, rt_d, use_rt_d, tu(0, tuse_rt), h, s_rt);
            checks++; if (fs_rs3 !== 2'(s_rs) || fs_rt3 !== 2'(s_rt)) begin failures++; $display("FAIL rnd_fwd3 cyc=%0d got=%0d/%0d exp=%0d/%0d", i, fs_rs3, fs_rt3, s_rs, s_rt); end
            eval_src(1, rs_d, use_rs_d, tu(1, tuse_rs), h, s_rs);
            eval_src(1, rt_d, use_rt_d, tu(1, tuse_rt), h, s_rt);
            checks++; if (fs_rs5 !== 3'(s_rs) || fs_rt5 !== 3'(s_rt)) begin failures++; $display("FAIL rnd_fwd5 cyc=%0d got=%0d/%0d exp=%0d/%0d", i, fs_rs5, fs_rt5, s_rs, s_rt); end
            checks++; if (cnt3 !== 16'(mcnt3) || cnt5 !== 4'(mcnt5)) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, cnt3, cnt5, mcnt3, mcnt5); end
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_branch_after_alu();
        test_shadowing();
        test_zero_and_flush();
        test_depth();
        test_saturation_and_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
